// File: rtl/score_sequencer.sv
// Write sequencer for the 4-digit score display: queues player points, issues
// round-robin spaced increment writes, detects game over and runs the clear sequence.
module score_sequencer #(
  parameter int PEND_W     = 3,
  parameter int GAP_CYCLES = 2,
  parameter int CLR_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_point,
  input  logic p2_point,
  input  logic start,
  input  logic disp_over,
  output logic disp_sel,
  output logic disp_addr,
  output logic disp_data,
  output logic disp_rst,
  output logic game_over,
  output logic winner,
  output logic overflow,
  output logic busy
);

  typedef enum logic [2:0] {S_RUN, S_ISSUE, S_GAP, S_OVER, S_CLEAR} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [3:0]        GAP_LD   = 4'(GAP_CYCLES);
  localparam logic [3:0]        CLR_LD   = 4'(CLR_CYCLES);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_tmr, w_tmr_nxt;
  logic [PEND_W-1:0]   r_pend1, r_pend2;
  logic                r_cur, w_cur_nxt;
  logic                r_last, w_last_nxt;
  logic                r_start_q;
  logic                w_start_edge;
  logic                w_grant;
  logic                w_count;
  logic                w_dec1, w_dec2;
  logic                w_lost;
  logic [PEND_W:0]     w_p1n, w_p2n;

  // Returns {point_lost, next_count}; a simultaneous increment and decrement cancel.
  function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) begin
      if (cnt == PEND_MAX) return {1'b1, cnt};
      return {1'b0, cnt + PEND_W'(1)};
    end
    if (dec && !inc) return {1'b0, cnt - PEND_W'(1)};
    return {1'b0, cnt};
  endfunction

  assign w_start_edge = start && !r_start_q;
  assign w_grant      = (|r_pend1 && |r_pend2) ? ~r_last : (r_pend1 == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_cur_nxt   = r_cur;
    w_last_nxt  = r_last;
    case (r_state)
      S_RUN: begin
        if (w_start_edge) begin
          w_state_nxt = S_CLEAR;
          w_tmr_nxt   = CLR_LD;
        end else if (disp_over) begin
          w_state_nxt = S_OVER;
        end else if (|r_pend1 || |r_pend2) begin
          w_state_nxt = S_ISSUE;
          w_cur_nxt   = w_grant;
          w_last_nxt  = w_grant;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_GAP;
        w_tmr_nxt   = GAP_LD;
      end
      S_GAP: begin
        // The display's updated flag is first valid on the last gap cycle.
        if (r_tmr == 4'd1) w_state_nxt = disp_over ? S_OVER : S_RUN;
        else               w_tmr_nxt   = r_tmr - 4'd1;
      end
      S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt = S_CLEAR;
          w_tmr_nxt   = CLR_LD;
        end
      end
      S_CLEAR: begin
        w_last_nxt = 1'b1;
        if (r_tmr == 4'd1) w_state_nxt = S_RUN;
        else               w_tmr_nxt   = r_tmr - 4'd1;
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_tmr_nxt   = CLR_LD;
      end
    endcase
  end

  // Points only count while play continues; entering OVER or CLEAR discards them.
  assign w_count = ((r_state == S_RUN) || (r_state == S_ISSUE) || (r_state == S_GAP)) &&
                   (w_state_nxt != S_OVER) && (w_state_nxt != S_CLEAR);
  assign w_dec1  = (r_state == S_ISSUE) && !r_cur;
  assign w_dec2  = (r_state == S_ISSUE) &&  r_cur;
  assign w_p1n   = pend_next(r_pend1, p1_point, w_dec1);
  assign w_p2n   = pend_next(r_pend2, p2_point, w_dec2);
  assign w_lost  = w_count && (w_p1n[PEND_W] || w_p2n[PEND_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_tmr     <= CLR_LD;
      r_pend1   <= '0;
      r_pend2   <= '0;
      r_cur     <= 1'b0;
      r_last    <= 1'b1;
      r_start_q <= 1'b0;
      disp_sel  <= 1'b0;
      disp_addr <= 1'b0;
      disp_data <= 1'b0;
      disp_rst  <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_pend1   <= w_count ? w_p1n[PEND_W-1:0] : '0;
      r_pend2   <= w_count ? w_p2n[PEND_W-1:0] : '0;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_start_q <= start;
      disp_sel  <= (w_state_nxt == S_ISSUE);
      disp_addr <= (w_state_nxt == S_ISSUE) && w_cur_nxt;
      disp_data <= (w_state_nxt == S_ISSUE);
      disp_rst  <= (w_state_nxt == S_CLEAR);
      game_over <= (w_state_nxt == S_OVER);
      winner    <= (w_state_nxt == S_OVER) && w_last_nxt;
      overflow  <= (w_state_nxt == S_CLEAR) ? 1'b0 : (overflow || w_lost);
      busy      <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_GAP) ||
                   (w_state_nxt == S_CLEAR);
    end
  end

endmodule
